// File: rtl/scale_row_sched.sv
// Per-frame row sequencer for the vertical scaler: steps dst_row through the frame,
// handshaking the line-RAM loader and the interpolation calculator for each row.
module scale_row_sched #(
    parameter int ROW_W   = 11,
    parameter int MUL_LAT = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [ROW_W-1:0] cfg_dst_rows,
    output logic [ROW_W-1:0] dst_row,
    output logic             wr_req,
    input  logic             tran_done,
    input  logic             out_rdy,
    output logic             calc_start,
    input  logic             calc_done,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout
);

    typedef enum logic [2:0] {
        IDLE, SETTLE, LOAD, WAIT_OUT, CALC_GO, CALC, NEXT, DONE
    } state_t;

    localparam int               SETTLE_W    = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(MUL_LAT);
    // The counter reads n-1 in the n-th cycle of LOAD/CALC, so expiry is flagged
    // in the cycle where the incremented count would reach TIMEOUT-1.
    localparam logic [15:0]      WD_LAST     = 16'(TIMEOUT - 2);

    state_t              state;
    state_t              state_nxt;
    logic [ROW_W-1:0]    rows;
    logic [15:0]         wd_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                last_row;
    logic                wd_expire;
    logic                timeout_hit;
    logic                frame_accept;

    assign last_row     = (dst_row == rows - ROW_W'(1));
    assign wd_expire    = (wd_cnt == WD_LAST);
    assign frame_accept = (state == IDLE) && frame_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = (cfg_dst_rows == '0) ? DONE : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                // A handshake arriving in the expiry cycle still counts as success.
                if (tran_done) begin
                    state_nxt = WAIT_OUT;
                end else if (wd_expire) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            WAIT_OUT: begin
                if (out_rdy) begin
                    state_nxt = CALC_GO;
                end
            end
            CALC_GO: state_nxt = CALC;
            CALC: begin
                if (calc_done) begin
                    state_nxt = NEXT;
                end else if (wd_expire) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            NEXT:    state_nxt = last_row ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_row     <= '0;
            rows        <= '0;
            wr_req      <= 1'b0;
            calc_start  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            wd_cnt      <= '0;
            settle_cnt  <= '0;
        end else begin
            wr_req     <= (state_nxt == LOAD);
            calc_start <= (state_nxt == CALC_GO);
            busy       <= (state_nxt != IDLE);
            frame_done <= (state_nxt == DONE);

            if (frame_accept) begin
                rows        <= cfg_dst_rows;
                dst_row     <= '0;
                err_timeout <= 1'b0;
            end else if (state == NEXT && !last_row) begin
                dst_row <= dst_row + ROW_W'(1);
            end

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end

            if (state_nxt != state) begin
                wd_cnt <= '0;
            end else if (state == LOAD || state == CALC) begin
                wd_cnt <= wd_cnt + 16'd1;
            end

            if (state_nxt != state) begin
                settle_cnt <= '0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_scale_row_sched.sv
// Directed bench for scale_row_sched: loader/calculator reply models drive the handshakes,
// and a queue of expected dst_row values is checked at every calc_start pulse.
module tb_scale_row_sched;

    localparam int ROW_W   = 11;
    localparam int MUL_LAT = 1;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_start;
    logic [ROW_W-1:0] cfg_dst_rows;
    logic [ROW_W-1:0] dst_row;
    logic             wr_req;
    logic             tran_done;
    logic             out_rdy;
    logic             calc_start;
    logic             calc_done;
    logic             busy;
    logic             frame_done;
    logic             err_timeout;

    always #5 clk = ~clk;

    scale_row_sched #(.ROW_W(ROW_W), .MUL_LAT(MUL_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_dst_rows(cfg_dst_rows),
        .dst_row(dst_row), .wr_req(wr_req), .tran_done(tran_done), .out_rdy(out_rdy),
        .calc_start(calc_start), .calc_done(calc_done), .busy(busy),
        .frame_done(frame_done), .err_timeout(err_timeout)
    );

    int nvec = 0;
    int nerr = 0;
    int sb[$];

    int cs_cnt = 0, wr_cnt = 0, fd_cnt = 0, wr_hi_cycles = 0;
    int cyc = 0, last_cs_cyc = 0, cs_gap = 0;
    logic             wr_prev = 1'b0;
    logic [ROW_W-1:0] row_prev = '0;

    int ld_dly = 1, cl_dly = 1;
    bit ld_en = 1'b1;

    task automatic check(input string tag, input longint got, input longint exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: scoreboard pop on calc_start plus event counters.
    always @(negedge clk) begin
        int exp_row;
        cyc++;
        if (!rst) begin
            if (calc_start) begin
                cs_gap      = cyc - last_cs_cyc;
                last_cs_cyc = cyc;
                cs_cnt++;
                exp_row = (sb.size() > 0) ? sb.pop_front() : -1;
                check("sb_row", dst_row, exp_row);
            end
            if (wr_req && !wr_prev) wr_cnt++;
            if (wr_req) wr_hi_cycles++;
            if (wr_req && wr_prev) check("row_stable", dst_row, row_prev);
            if (frame_done) fd_cnt++;
        end
        wr_prev  = wr_req;
        row_prev = dst_row;
    end

    // Loader model: pulses tran_done ld_dly cycles into a wr_req window.
    initial begin
        int ld_cnt;
        ld_cnt    = 0;
        tran_done = 1'b0;
        forever begin
            @(negedge clk);
            tran_done = 1'b0;
            if (ld_en && wr_req) begin
                ld_cnt++;
                if (ld_cnt == ld_dly) begin
                    tran_done = 1'b1;
                    ld_cnt    = 0;
                end
            end else begin
                ld_cnt = 0;
            end
        end
    end

    // Calculator model: pulses calc_done cl_dly cycles after calc_start; it keeps running through rst.
    initial begin
        int cl_cnt;
        bit cl_busy;
        cl_cnt    = 0;
        cl_busy   = 1'b0;
        calc_done = 1'b0;
        forever begin
            @(negedge clk);
            calc_done = 1'b0;
            if (cl_busy) begin
                cl_cnt++;
                if (cl_cnt == cl_dly) begin
                    calc_done = 1'b1;
                    cl_busy   = 1'b0;
                end
            end
            if (calc_start) begin
                cl_busy = 1'b1;
                cl_cnt  = 0;
            end
        end
    end

    task automatic clear_counts();
        @(negedge clk);
        cs_cnt       = 0;
        wr_cnt       = 0;
        fd_cnt       = 0;
        wr_hi_cycles = 0;
    endtask

    task automatic push_rows(input int n);
        for (int i = 0; i < n; i++) sb.push_back(i);
    endtask

    task automatic start_frame(input int n);
        @(negedge clk);
        cfg_dst_rows = ROW_W'(n);
        frame_start  = 1'b1;
        @(negedge clk);
        frame_start  = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (fd_cnt >= target) break;
            @(negedge clk);
        end
        check(tag, fd_cnt, target);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dst_row"}, dst_row, 0);
        check({tag, "_wr_req"}, wr_req, 0);
        check({tag, "_calc_start"}, calc_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_err"}, err_timeout, 0);
    endtask

    initial begin
        int bad_cs, bad_wr, bad_err;
        rst          = 1'b1;
        frame_start  = 1'b0;
        cfg_dst_rows = '0;
        out_rdy      = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;

        // Three rows, replies five cycles after each request.
        clear_counts();
        ld_dly = 5; cl_dly = 5;
        push_rows(3);
        start_frame(3);
        wait_fd("t1_frame_done", 1, 500);
        @(negedge clk);
        check("t1_calc_starts", cs_cnt, 3);
        check("t1_wr_windows", wr_cnt, 3);
        check("t1_busy_after", busy, 0);
        check("t1_err", err_timeout, 0);
        check("t1_sb_empty", sb.size(), 0);

        // Downstream stall after the first load.
        clear_counts();
        out_rdy = 1'b0;
        push_rows(2);
        start_frame(2);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_cnt >= 1 && !wr_req) break;
        end
        bad_cs = 0; bad_wr = 0; bad_err = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (calc_start) bad_cs++;
            if (wr_req) bad_wr++;
            if (err_timeout) bad_err++;
        end
        check("t2_stall_calc_start", bad_cs, 0);
        check("t2_stall_wr_req", bad_wr, 0);
        check("t2_stall_err", bad_err, 0);
        check("t2_stall_busy", busy, 1);
        out_rdy = 1'b1;
        wait_fd("t2_frame_done", 1, 500);
        check("t2_calc_starts", cs_cnt, 2);
        check("t2_err_after", err_timeout, 0);

        // Loader never answers: watchdog abort.
        clear_counts();
        ld_en = 1'b0;
        start_frame(2);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("t3_wr_hi_cycles", wr_hi_cycles, TIMEOUT - 1);
        check("t3_err", err_timeout, 1);
        check("t3_wr_req", wr_req, 0);
        check("t3_busy", busy, 0);
        check("t3_no_frame_done", fd_cnt, 0);
        check("t3_no_calc_start", cs_cnt, 0);
        ld_en = 1'b1;
        push_rows(1);
        start_frame(1);
        check("t3_err_cleared", err_timeout, 0);
        wait_fd("t3_frame_done", 1, 500);
        check("t3_calc_starts", cs_cnt, 1);

        // Zero-row frame.
        clear_counts();
        start_frame(0);
        wait_fd("t4_frame_done", 1, 4);
        check("t4_wr_windows", wr_cnt, 0);
        check("t4_calc_starts", cs_cnt, 0);
        check("t4_busy_after", busy, 0);

        // frame_start mid-frame is ignored.
        clear_counts();
        ld_dly = 2; cl_dly = 2;
        push_rows(4);
        start_frame(4);
        repeat (10) @(negedge clk);
        cfg_dst_rows = ROW_W'(9);
        frame_start  = 1'b1;
        @(negedge clk);
        frame_start  = 1'b0;
        wait_fd("t5_frame_done", 1, 500);
        check("t5_calc_starts", cs_cnt, 4);
        check("t5_sb_empty", sb.size(), 0);
        check("t5_dst_row_hold", dst_row, 3);

        // Reset during CALC of row 4, then a stray calc_done.
        clear_counts();
        ld_dly = 1; cl_dly = 10;
        push_rows(6);
        start_frame(6);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cs_cnt >= 5) break;
        end
        repeat (2) @(negedge clk);
        check("t6_row4", dst_row, 4);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        sb.delete();
        repeat (15) @(negedge clk);
        check("t6_busy_after", busy, 0);
        check("t6_no_calc_start", cs_cnt, 5);
        check("t6_no_frame_done", fd_cnt, 0);
        check("t6_dst_row_after", dst_row, 0);

        // Maximum row count with immediate replies: no wrap, minimum row period.
        clear_counts();
        ld_dly = 1; cl_dly = 1;
        push_rows(2047);
        start_frame(2047);
        wait_fd("t7_frame_done", 1, 20000);
        check("t7_calc_starts", cs_cnt, 2047);
        check("t7_sb_empty", sb.size(), 0);
        check("t7_last_row", dst_row, 2046);
        check("t7_row_period", cs_gap, MUL_LAT + 6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
